// File: rtl/dram_block_responder.sv
// rtl/dram_block_responder.sv - DRAM block read/write-back responder with SRAM model
module dram_block_responder #(
  parameter int BLOCK_SIZE = 8,
  parameter int ADDR_W     = 12,
  parameter int RD_LATENCY = 4,
  parameter int WR_LATENCY = 2
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        dram_wr_req,
  input  logic [31:0] dram_wr_addr,
  input  logic [31:0] dram_wr_data,
  output logic        dram_wr_val,
  input  logic        dram_rd_req,
  input  logic [31:0] dram_rd_addr,
  output logic [31:0] dram_rd_data,
  output logic        dram_rd_val,
  input  logic        stall,
  output logic        busy
);

  localparam int OFF_W   = $clog2(BLOCK_SIZE);
  localparam int BEAT_W  = OFF_W + 1;
  localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_WAIT,
    WR_BURST,
    WR_LAST,
    DONE
  } state_t;

  state_t                    state;
  logic [ADDR_W-OFF_W-1:0]   blk_q;
  logic [BEAT_W-1:0]         beat;
  logic [LAT_W-1:0]          lat_cnt;
  logic [ADDR_W-1:0]         word_idx;
  logic [ADDR_W-1:0]         val_idx;
  logic [ADDR_W-1:0]         cap_idx;
  logic                      cap_valid;
  logic                      lat_at_one;
  logic [31:0]               mem [0:(1<<ADDR_W)-1];
  logic                      unused_addr_bits;

  // Block base comes from the latched request; only the low beat bits walk the block.
  assign word_idx   = {blk_q, beat[OFF_W-1:0]};
  assign lat_at_one = (lat_cnt == LAT_W'(1));
  assign busy       = (state != IDLE);

  // High bits alias and the in-block offset is ignored.
  assign unused_addr_bits = ^{dram_wr_addr[31:ADDR_W], dram_wr_addr[OFF_W-1:0],
                              dram_rd_addr[31:ADDR_W], dram_rd_addr[OFF_W-1:0]};

  // Request sequencing, beat issue and the one-cycle-late write capture pipeline.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      blk_q        <= '0;
      beat         <= '0;
      lat_cnt      <= '0;
      dram_rd_val  <= 1'b0;
      dram_wr_val  <= 1'b0;
      dram_rd_data <= '0;
      val_idx      <= '0;
      cap_valid    <= 1'b0;
      cap_idx      <= '0;
    end else begin
      dram_rd_val <= 1'b0;
      dram_wr_val <= 1'b0;
      // The initiator presents a beat's word in the cycle after its val pulse.
      cap_valid   <= dram_wr_val;
      cap_idx     <= val_idx;
      case (state)
        IDLE: begin
          beat <= '0;
          if (dram_wr_req) begin
            blk_q   <= dram_wr_addr[ADDR_W-1:OFF_W];
            lat_cnt <= LAT_W'(WR_LATENCY);
            state   <= WR_WAIT;
          end else if (dram_rd_req) begin
            blk_q   <= dram_rd_addr[ADDR_W-1:OFF_W];
            lat_cnt <= LAT_W'(RD_LATENCY);
            state   <= RD_WAIT;
          end
        end
        RD_WAIT, RD_BURST: begin
          if (!dram_rd_req) begin
            state <= IDLE;
          end else if (state == RD_WAIT && !lat_at_one) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else begin
            state <= RD_BURST;
            if (!stall) begin
              dram_rd_val  <= 1'b1;
              dram_rd_data <= mem[word_idx];
              beat         <= beat + BEAT_W'(1);
              if (beat == BEAT_W'(BLOCK_SIZE - 1)) state <= DONE;
            end
          end
        end
        WR_WAIT, WR_BURST: begin
          if (!dram_wr_req) begin
            state <= IDLE;
          end else if (state == WR_WAIT && !lat_at_one) begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end else if (beat == BEAT_W'(BLOCK_SIZE)) begin
            state <= WR_LAST;
          end else begin
            state <= WR_BURST;
            if (!stall) begin
              dram_wr_val <= 1'b1;
              val_idx     <= word_idx;
              beat        <= beat + BEAT_W'(1);
            end
          end
        end
        WR_LAST: state <= DONE;
        DONE: begin
          // Swallow the initiator's extra hold cycle so no block is served twice.
          if (!dram_wr_req && !dram_rd_req) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory array is never reset; captured write words land here.
  always_ff @(posedge clock) begin
    if (cap_valid) mem[cap_idx] <= dram_wr_data;
  end

endmodule

// File: tb/tb_dram_block_responder.sv
// tb/tb_dram_block_responder.sv - self-checking bench for dram_block_responder
module tb_dram_block_responder;

  localparam int BS     = 8;
  localparam int AW     = 12;
  localparam int RD_LAT = 4;
  localparam int WR_LAT = 2;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        dram_wr_req;
  logic [31:0] dram_wr_addr;
  logic [31:0] dram_wr_data;
  logic        dram_wr_val;
  logic        dram_rd_req;
  logic [31:0] dram_rd_addr;
  logic [31:0] dram_rd_data;
  logic        dram_rd_val;
  logic        stall;
  logic        busy;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] ref_mem [int unsigned];

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] base;
    logic [31:0] smask;
    int          hold;
    int          exp_first;
  } vec_t;

  dram_block_responder #(
    .BLOCK_SIZE(BS),
    .ADDR_W    (AW),
    .RD_LATENCY(RD_LAT),
    .WR_LATENCY(WR_LAT)
  ) dut (
    .clock       (clock),
    .rst_n       (rst_n),
    .dram_wr_req (dram_wr_req),
    .dram_wr_addr(dram_wr_addr),
    .dram_wr_data(dram_wr_data),
    .dram_wr_val (dram_wr_val),
    .dram_rd_req (dram_rd_req),
    .dram_rd_addr(dram_rd_addr),
    .dram_rd_data(dram_rd_data),
    .dram_rd_val (dram_rd_val),
    .stall       (stall),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Word address of beat j of the block holding address a (aliasing by modulo).
  function automatic int unsigned widx(input logic [31:0] a, input int j);
    int unsigned base;
    base = a % (32'd1 << AW);
    return (base / BS) * BS + j;
  endfunction

  // One complete transfer driven by a cache-like initiator; the reference model
  // predicts every val sample from latency and the stall pattern.
  task automatic run_xfer(input bit wr, input logic [31:0] addr, input logic [31:0] base,
                          input logic [31:0] smask, input int hold, input bit also_rd,
                          output int first);
    int lat, issued, seen, k, drop_at, idle_exp, idle_got, k8, prev_beat;
    bit prev_val, exp_v, got_v;
    lat = wr ? WR_LAT : RD_LAT;
    issued = 0; seen = 0; first = -1; drop_at = -1; idle_exp = -2; idle_got = -1;
    k8 = -1; prev_val = 1'b0; prev_beat = 0;
    @(negedge clock);
    if (wr) begin
      dram_wr_req  = 1'b1;
      dram_wr_addr = addr;
      dram_rd_req  = also_rd;
      dram_rd_addr = 32'h100;
    end else begin
      dram_rd_req  = 1'b1;
      dram_rd_addr = addr;
    end
    stall = smask[0];
    for (k = 1; k < 200 && idle_got < 0; k++) begin
      @(negedge clock);
      got_v = wr ? dram_wr_val : dram_rd_val;
      exp_v = (k >= lat + 1) && (issued < BS) && !((k - 1) < 32 && smask[k-1]);
      if (exp_v) issued++;
      check("val", got_v, exp_v);
      check("other_val", wr ? dram_rd_val : dram_wr_val, 1'b0);
      if (got_v) begin
        if (first < 0) first = k;
        if (!wr && ref_mem.exists(widx(addr, seen)))
          check("rd_data", dram_rd_data, ref_mem[widx(addr, seen)]);
        seen++;
      end
      if (idle_got < 0 && !busy) idle_got = k;
      // Drive inputs for the next cycle.
      if (wr) dram_wr_data = prev_val ? base + prev_beat : $urandom();
      prev_val  = got_v;
      prev_beat = seen - 1;
      if (wr && k == 1) dram_rd_req = 1'b0;
      stall = (k < 32) ? smask[k] : 1'b0;
      if (seen == BS && drop_at < 0) begin
        k8       = k;
        drop_at  = k + hold;
        idle_exp = wr ? ((drop_at + 1 > k8 + 3) ? drop_at + 1 : k8 + 3) : drop_at + 1;
      end
      if (k == drop_at) begin
        dram_wr_req = 1'b0;
        dram_rd_req = 1'b0;
      end
    end
    dram_wr_req = 1'b0;
    dram_rd_req = 1'b0;
    stall       = 1'b0;
    check("beats", seen, BS);
    check("busy_drop", idle_got, idle_exp);
    if (wr) for (int j = 0; j < BS; j++) ref_mem[widx(addr, j)] = base + j;
  endtask

  initial begin
    vec_t        vecs[11];
    int          first;
    int          seen;
    logic [31:0] r;
    logic [31:0] a;

    rst_n = 1'b0; dram_wr_req = 1'b0; dram_rd_req = 1'b0; stall = 1'b0;
    dram_wr_addr = '0; dram_rd_addr = '0; dram_wr_data = '0;
    repeat (3) @(negedge clock);
    check("rst_rd_val", dram_rd_val, 1'b0);
    check("rst_wr_val", dram_wr_val, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rd_data", dram_rd_data, 32'h0);
    rst_n = 1'b1;
    @(negedge clock);

    vecs[0]  = '{1'b1, 32'h0000_0100, 32'hA0, 32'h000, 1, 3};
    vecs[1]  = '{1'b0, 32'h0000_0100, 32'h00, 32'h000, 1, 5};
    vecs[2]  = '{1'b1, 32'h0000_0208, 32'hD0, 32'h000, 1, 3};
    vecs[3]  = '{1'b0, 32'h0000_020B, 32'h00, 32'h000, 1, 5};
    vecs[4]  = '{1'b0, 32'h0000_0100, 32'h00, 32'h180, 1, 5};
    vecs[5]  = '{1'b1, 32'h0000_0300, 32'h50, 32'h060, 1, 3};
    vecs[6]  = '{1'b0, 32'h0000_0300, 32'h00, 32'h000, 1, 5};
    vecs[7]  = '{1'b0, 32'h0000_0208, 32'h00, 32'h000, 2, 5};
    vecs[8]  = '{1'b0, 32'h0000_0208, 32'h00, 32'h030, 1, 7};
    vecs[9]  = '{1'b1, 32'h0000_0300, 32'h60, 32'h004, 2, 4};
    vecs[10] = '{1'b0, 32'h0000_1300, 32'h00, 32'h000, 1, 5};
    for (int i = 0; i < 11; i++) begin
      run_xfer(vecs[i].wr, vecs[i].addr, vecs[i].base, vecs[i].smask, vecs[i].hold, 1'b0, first);
      check("first_val", first, vecs[i].exp_first);
    end

    // Both requests together: the write to the aliased block wins.
    run_xfer(1'b1, 32'h0000_1000, 32'hE0, 32'h0, 1, 1'b1, first);
    run_xfer(1'b0, 32'h0000_0000, 32'h0, 32'h0, 1, 1'b0, first);
    run_xfer(1'b0, 32'h0000_0100, 32'h0, 32'h0, 1, 1'b0, first);

    // Asynchronous reset in the middle of a read burst.
    @(negedge clock);
    dram_rd_req = 1'b1; dram_rd_addr = 32'h100;
    seen = 0;
    for (int k = 0; k < 40 && seen < 3; k++) begin
      @(negedge clock);
      if (dram_rd_val) seen++;
    end
    check("pre_reset_beats", seen, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_rd_val", dram_rd_val, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_rd_data", dram_rd_data, 32'h0);
    @(negedge clock);
    rst_n = 1'b1; dram_rd_req = 1'b0;
    @(negedge clock);
    run_xfer(1'b0, 32'h0000_0100, 32'h0, 32'h0, 1, 1'b0, first);

    // Randomised traffic over 16 blocks with aliasing, stalls and hold lengths.
    for (int i = 0; i < 16; i++) begin
      r = $urandom();
      a = (r & 32'hFFFF_F000) | (32'h400 + i * BS) | (r & 32'h7);
      run_xfer(1'b1, a, $urandom(), $urandom() & $urandom() & $urandom(),
               $urandom_range(1, 2), 1'b0, first);
    end
    for (int i = 0; i < 40; i++) begin
      r = $urandom();
      a = (r & 32'hFFFF_F000) | (32'h400 + $urandom_range(0, 15) * BS) | (r & 32'h7);
      run_xfer($urandom_range(0, 2) == 0, a, $urandom(), $urandom() & $urandom() & $urandom(),
               $urandom_range(1, 2), 1'b0, first);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
